shift_register: RTL and testbench

- Fixed-latency delay line: WIDTH-bit words pass through LENGTH cascaded register stages.
- Used to align datapath timing, e.g. to match pipeline depth between parallel paths.
- No handshake and no stall: one word is accepted and one word is emitted on every clock edge.

---
 rtl/shift_register.sv | 76 +++++++
 tb/tb_shift_register.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// -----------------------------------------------------------------------------
// shift_register
//
// Fixed-latency delay line. WIDTH-bit words travel through LENGTH cascaded
// register stages, so every word appears on data_out exactly LENGTH clocks
// after it was captured. Typical use is to match pipeline depth between
// parallel datapaths.
//
// Flow control: there is no valid/ready handshake and no stall. One word is
// accepted on data_in and one word is emitted on data_out on every rising
// clock edge, unconditionally.
//
// Parameters:
//   WIDTH   word width in bits (>= 1)
//   LENGTH  number of stages, equal to the latency in clocks (>= 1)
//
// Ports:
//   clock     in   1             rising-edge clock
//   reset     in   1             synchronous active-high reset, clears all stages
//   data_in   in   WIDTH         word captured into stage 0 on each edge
//   data_out  out  WIDTH         last stage (LENGTH-1), registered output
//   taps      out  WIDTH*LENGTH  all stages, stage 0 in the LSBs
//                                (present only when SHIFT_REGISTER_TAPS_EN
//                                is defined)
//
// Optional feature macro: SHIFT_REGISTER_TAPS_EN
// -----------------------------------------------------------------------------
module shift_register #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        data_in,
`ifdef SHIFT_REGISTER_TAPS_EN
  output logic [WIDTH*LENGTH-1:0] taps,
`endif
  output logic [WIDTH-1:0]        data_out
);

  // Reject illegal geometry at elaboration time.
  if (WIDTH < 1 || LENGTH < 1) begin : g_param_check
    $error("shift_register: WIDTH and LENGTH must both be >= 1");
  end

  // Packed so that element k occupies bits [WIDTH*(k+1)-1 : WIDTH*k]; the
  // whole vector is then exactly the taps layout with stage 0 in the LSBs.
  logic [LENGTH-1:0][WIDTH-1:0] stage_q;
  logic [LENGTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = data_in;
    // Loop body never runs when LENGTH == 1, leaving a single register.
    for (int k = 1; k < LENGTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Reset wins over data: in-flight words are discarded on the first edge
  // with reset high.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign data_out = stage_q[LENGTH-1];

`ifdef SHIFT_REGISTER_TAPS_EN
  assign taps = stage_q;
`endif

endmodule

// File: tb/tb_shift_register.sv
// -----------------------------------------------------------------------------
// tb_shift_register
//
// Directed bench for shift_register. Two instances share clock and reset:
// u_dut4 (WIDTH=8, LENGTH=4) and u_dut1 (WIDTH=8, LENGTH=1). Inputs are
// driven on the falling edge, outputs are sampled #1 after the rising edge.
// Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_shift_register;

  logic        clock;
  logic        reset;
  logic [7:0]  data_in4;
  logic [7:0]  data_out4;
  logic [7:0]  data_in1;
  logic [7:0]  data_out1;
`ifdef SHIFT_REGISTER_TAPS_EN
  logic [31:0] taps4;
  logic [7:0]  taps1;
`endif

  int pass_cnt;
  int total_cnt;

  // ---------------------------------------------------------------- clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------- DUTs
  shift_register #(.WIDTH(8), .LENGTH(4)) u_dut4 (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in4),
`ifdef SHIFT_REGISTER_TAPS_EN
    .taps     (taps4),
`endif
    .data_out (data_out4)
  );

  shift_register #(.WIDTH(8), .LENGTH(1)) u_dut1 (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in1),
`ifdef SHIFT_REGISTER_TAPS_EN
    .taps     (taps1),
`endif
    .data_out (data_out1)
  );

  // ---------------------------------------------------------------- driver tasks
  // Apply inputs away from the active edge, then advance one rising edge and
  // settle so outputs reflect that edge.
  task automatic step(input logic rst, input logic [7:0] d4, input logic [7:0] d1);
    @(negedge clock);
    reset    = rst;
    data_in4 = d4;
    data_in1 = d1;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [7:0] stream_in  [12];
  logic [7:0] stream_exp [12];

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    data_in4  = 8'h00;
    data_in1  = 8'h00;

    stream_in  = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56,
                   8'h67, 8'h78, 8'h89, 8'h9A, 8'hAB, 8'hBC};
    // Three zero words from the flushed pipe, then the stream in order.
    stream_exp = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h23,
                   8'h34, 8'h45, 8'h56, 8'h67, 8'h78, 8'h89};

    // Reset flush: two edges with reset high.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'h00, 8'h00);
      check($sformatf("reset_flush_%0d", i), {24'h0, data_out4}, 32'h0);
    end
    check("reset_flush_len1", {24'h0, data_out1}, 32'h0);

    // Streaming through LENGTH=4.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, stream_in[i], 8'h00);
      check($sformatf("stream_%0d", i), {24'h0, data_out4}, {24'h0, stream_exp[i]});
    end

    // Mid-stream reset: a single edge discards everything in flight.
    step(1'b1, 8'hEE, 8'h00);
    check("midreset_out", {24'h0, data_out4}, 32'h0);

    // Restart from zero with a constant 5A input.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h5A, 8'h00);
      check($sformatf("restart_zero_%0d", i), {24'h0, data_out4}, 32'h0);
    end
    step(1'b0, 8'h5A, 8'h00);
    check("restart_5a", {24'h0, data_out4}, 32'h0000_005A);

    // Reset priority: data_in = FF is ignored while reset is high.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hFF, 8'hFF);
      check($sformatf("rst_prio4_%0d", i), {24'h0, data_out4}, 32'h0);
      check($sformatf("rst_prio1_%0d", i), {24'h0, data_out1}, 32'h0);
    end

    // LENGTH=1 instance: single-register behaviour.
    step(1'b0, 8'h00, 8'h3C);
    check("len1_3c", {24'h0, data_out1}, 32'h0000_003C);
    step(1'b0, 8'h00, 8'hC3);
    check("len1_c3", {24'h0, data_out1}, 32'h0000_00C3);

`ifdef SHIFT_REGISTER_TAPS_EN
    // Taps: reset, then load four words.
    step(1'b1, 8'h00, 8'h00);
    check("taps_reset", taps4, 32'h0);
    step(1'b0, 8'h01, 8'h00);
    step(1'b0, 8'h12, 8'h00);
    step(1'b0, 8'h23, 8'h00);
    step(1'b0, 8'h34, 8'h00);
    check("taps_full", taps4, 32'h0112_2334);
    check("taps_data_out", {24'h0, data_out4}, 32'h0000_0001);
`endif

    // ---------------------------------------------------------------- report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
